cbz_branch_controller: RTL

//  Sequences conditional (CBZ/CBNZ) and unconditional (B) branch resolution for the LEGv8 core.

---
 rtl/cbz_branch_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cbz_branch_controller.sv
// LEGv8 branch resolution sequencer: CBZ/CBNZ/B accept, target compute, PCSrc redirect and flush window.
// Optional statistics counters are compiled in when BRANCH_STATS_EN is defined.
module cbz_branch_controller #(
   parameter int ADDR_W       = 64,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              dec_valid,
   input  logic              Branch,
   input  logic              UncondBranch,
   input  logic              CondInvert,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [ADDR_W-1:0] br_offset,
   input  logic              alu_valid,
   input  logic              Zero,
   output logic              req_ack,
   output logic              stall,
   output logic              PCSrc,
   output logic [ADDR_W-1:0] pc_target,
   output logic              flush,
   output logic              resolved,
`ifdef BRANCH_STATS_EN
   output logic [CNT_W-1:0]  taken_count,
   output logic [CNT_W-1:0]  resolve_count,
`endif
   output logic              taken
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ALU = 2'd1,
      REDIRECT = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);

   if (ADDR_W < 1 || CNT_W < 1 || FLUSH_CYCLES < 0) begin : g_param_check
      $error("cbz_branch_controller: illegal parameter combination");
   end

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_target_q, pc_target_d;
   logic                inv_q, inv_d;
   logic                branch_q, branch_d;
   logic                uncond_q, uncond_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                stall_q, pcsrc_q, flush_q;

   logic                accept_s;
   logic                alu_hit_s;
   logic                cond_taken_s;
   logic                b_resolve_s;
   logic                resolved_s;
   logic                taken_s;

   // Request/resolve qualifiers; req_ack, resolved and taken must answer in the same cycle as their inputs.
   always_comb begin
      accept_s     = ~RESET & (state_q == IDLE) & dec_valid & (Branch | UncondBranch);
      alu_hit_s    = (state_q == WAIT_ALU) & alu_valid;
      cond_taken_s = branch_q & (Zero ^ inv_q);
      b_resolve_s  = (state_q == REDIRECT) & uncond_q;
      resolved_s   = alu_hit_s | b_resolve_s;
      taken_s      = (alu_hit_s & cond_taken_s) | b_resolve_s;
   end

   // Next-state and datapath capture for the branch sequencer.
   always_comb begin
      state_d     = state_q;
      pc_target_d = pc_target_q;
      inv_d       = inv_q;
      branch_d    = branch_q;
      uncond_d    = uncond_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               pc_target_d = pc_in + (br_offset << 2);
               inv_d       = CondInvert;
               branch_d    = Branch;
               uncond_d    = UncondBranch;
               state_d     = UncondBranch ? REDIRECT : WAIT_ALU;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_ALU: begin
            if (alu_valid) begin
               state_d = cond_taken_s ? REDIRECT : IDLE;
            end else begin
               state_d = WAIT_ALU;
            end
         end
         REDIRECT: begin
            if (FLUSH_CYCLES == 0) begin
               state_d = IDLE;
            end else begin
               state_d = FLUSH;
               cnt_d   = CNT_LOAD;
            end
         end
         FLUSH: begin
            if (cnt_q == {CW{1'b0}}) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, captured branch fields and state-decoded outputs, registered from the next state.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         pc_target_q <= {ADDR_W{1'b0}};
         inv_q       <= 1'b0;
         branch_q    <= 1'b0;
         uncond_q    <= 1'b0;
         cnt_q       <= {CW{1'b0}};
         stall_q     <= 1'b0;
         pcsrc_q     <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_target_q <= pc_target_d;
         inv_q       <= inv_d;
         branch_q    <= branch_d;
         uncond_q    <= uncond_d;
         cnt_q       <= cnt_d;
         stall_q     <= (state_d != IDLE);
         pcsrc_q     <= (state_d == REDIRECT);
         flush_q     <= (state_d == REDIRECT) || (state_d == FLUSH);
      end
   end

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] taken_cnt_q;
   logic [CNT_W-1:0] resolve_cnt_q;

   // Saturating outcome statistics.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         taken_cnt_q   <= {CNT_W{1'b0}};
         resolve_cnt_q <= {CNT_W{1'b0}};
      end else begin
         if (resolved_s && taken_s && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_q <= taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (resolved_s && (resolve_cnt_q != {CNT_W{1'b1}})) begin
            resolve_cnt_q <= resolve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign taken_count   = taken_cnt_q;
   assign resolve_count = resolve_cnt_q;
`endif

   assign req_ack   = accept_s;
   assign resolved  = resolved_s;
   assign taken     = taken_s;
   assign stall     = stall_q;
   assign PCSrc     = pcsrc_q;
   assign flush     = flush_q;
   assign pc_target = pc_target_q;

endmodule
